// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. A two-flop synchroniser feeds a single
// registered FSM. The FSM samples each bit once, at the middle of the bit,
// and reports a good byte or a framing error with a one-cycle pulse.
module uart_rx #(
  parameter int CLK_CY_PER_BIT = 87
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_Dv,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  // Mid-bit offset measured from the first low sample of the start bit.
  localparam int HALF_BIT = (CLK_CY_PER_BIT - 1) / 2;

  // The START state is entered on cycle 1 with the counter at 0, so the start
  // check at cycle HALF_BIT happens when the counter reads HALF_BIT-1.
  localparam logic [7:0] START_LAST = 8'(HALF_BIT - 1);
  // Between sample points the counter runs 0..CLK_CY_PER_BIT-1.
  localparam logic [7:0] BIT_LAST   = 8'(CLK_CY_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4,
    S_BREAK   = 3'd5
  } state_t;

  logic       rx_meta_q;
  logic       rx_sync_q;
  logic       s_rx;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q;
  logic [7:0] byte_q;
  logic       dv_q;
  logic       err_q;
  logic       active_q;

  // Two-flop synchroniser; both stages reset to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign s_rx = rx_sync_q;

  // Receive FSM: bit timing, data assembly and the registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 3'd0;
      shift_q  <= 8'd0;
      byte_q   <= 8'd0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      // Pulses last a single cycle unless re-asserted below.
      dv_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q    <= 8'd0;
          idx_q    <= 3'd0;
          active_q <= 1'b0;
          if (!s_rx) begin
            state_q  <= S_START;
            active_q <= 1'b1;
          end
        end

        S_START: begin
          if (cnt_q == START_LAST) begin
            cnt_q <= 8'd0;
            if (s_rx) begin
              // Line went back high before mid start bit: a glitch.
              state_q  <= S_IDLE;
              active_q <= 1'b0;
            end else begin
              state_q <= S_DATA;
              idx_q   <= 3'd0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q          <= 8'd0;
            shift_q[idx_q] <= s_rx;
            if (idx_q == 3'd7) begin
              idx_q   <= 3'd0;
              state_q <= S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q    <= 8'd0;
            active_q <= 1'b0;
            if (s_rx) begin
              byte_q  <= shift_q;
              dv_q    <= 1'b1;
              state_q <= S_CLEANUP;
            end else begin
              // Low stop bit: framing error, then wait out any break.
              err_q   <= 1'b1;
              state_q <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        S_CLEANUP: begin
          active_q <= 1'b0;
          state_q  <= S_IDLE;
        end

        S_BREAK: begin
          active_q <= 1'b0;
          if (s_rx) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= 8'd0;
          idx_q    <= 3'd0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Rx_Dv        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = err_q;
  assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames onto the serial pin and checks pulse timing,
// received bytes, framing errors and the active flag against expectations
// computed from bit-period arithmetic.
module tb_uart_rx;

  localparam int N    = 87;
  localparam int HALF = (N - 1) / 2;
  // Pin start edge to o_Rx_Dv: 2 synchroniser cycles, stop sample, +1 register.
  localparam int LAT  = 2 + HALF + 9 * N + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pin;
  logic       dv;
  logic [7:0] rx_byte;
  logic       ferr;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frame_p  = 0;
  int both_cnt = 0;

  int         dv_cyc[$];
  logic [7:0] dv_byte[$];
  int         err_cyc[$];
  bit         act_log[100000];

  // Reference: last byte that should be visible on o_Rx_Byte.
  logic [7:0] last_good;

  uart_rx #(.CLK_CY_PER_BIT(N)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_Rx_Serial    (pin),
    .o_Rx_Dv        (dv),
    .o_Rx_Byte      (rx_byte),
    .o_Rx_Frame_Err (ferr),
    .o_Rx_Active    (active)
  );

  always #5 clk = ~clk;

  // Cycle counter advances at each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples outputs on the falling edge and logs every event.
  always @(negedge clk) begin
    if (cyc < 100000) act_log[cyc] <= active;
    if (dv) begin
      dv_cyc.push_back(cyc);
      dv_byte.push_back(rx_byte);
    end
    if (ferr) err_cyc.push_back(cyc);
    if (dv && ferr) both_cnt <= both_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit; each held N cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    logic [9:0] bits;
    bits    = {stop_val, b, 1'b0};
    frame_p = cyc;
    for (int j = 0; j < 10; j++) begin
      pin = bits[j];
      idle(N);
    end
  endtask

  task automatic test_reset();
    int ones;
    rst_n = 1'b0;
    pin   = 1'b1;
    idle(3);
    n_checks++; if (dv !== 1'b0)       begin n_fail++; $display("FAIL reset_dv: got %b expected 0", dv); end
    n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h expected 00", rx_byte); end
    n_checks++; if (ferr !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b expected 0", ferr); end
    n_checks++; if (active !== 1'b0)   begin n_fail++; $display("FAIL reset_active: got %b expected 0", active); end
    rst_n = 1'b1;
    idle(1000);
    ones = 0;
    for (int i = 0; i < cyc; i++) if (act_log[i]) ones++;
    n_checks++; if (dv_cyc.size() != 0)  begin n_fail++; $display("FAIL idle_dv_count: got %0d expected 0", dv_cyc.size()); end
    n_checks++; if (err_cyc.size() != 0) begin n_fail++; $display("FAIL idle_err_count: got %0d expected 0", err_cyc.size()); end
    n_checks++; if (rx_byte !== 8'h00)   begin n_fail++; $display("FAIL idle_byte: got %h expected 00", rx_byte); end
    n_checks++; if (ones != 0)           begin n_fail++; $display("FAIL idle_active: got %0d active cycles expected 0", ones); end
    last_good = 8'h00;
    $display("reset: released, line idle 1000 cycles");
  endtask

  task automatic test_single_frame();
    int b0, e0, p;
    b0 = dv_cyc.size();
    e0 = err_cyc.size();
    send_frame(8'hA5, 1'b1);
    p = frame_p;
    idle(100);
    last_good = 8'hA5;
    n_checks++; if (dv_cyc.size() != b0 + 1) begin n_fail++; $display("FAIL a5_dv_count: got %0d expected %0d", dv_cyc.size(), b0 + 1); end
    else begin
      n_checks++; if (dv_cyc[b0] != p + LAT)  begin n_fail++; $display("FAIL a5_latency: got %0d expected %0d", dv_cyc[b0] - p, LAT); end
      n_checks++; if (dv_byte[b0] !== 8'hA5) begin n_fail++; $display("FAIL a5_byte: got %h expected a5", dv_byte[b0]); end
    end
    n_checks++; if (rx_byte !== 8'hA5)        begin n_fail++; $display("FAIL a5_byte_held: got %h expected a5", rx_byte); end
    n_checks++; if (err_cyc.size() != e0)     begin n_fail++; $display("FAIL a5_err: got %0d errors expected %0d", err_cyc.size(), e0); end
    n_checks++; if (act_log[p + 2] !== 1'b0)  begin n_fail++; $display("FAIL a5_active_c0: got %b expected 0", act_log[p + 2]); end
    n_checks++; if (act_log[p + 3] !== 1'b1)  begin n_fail++; $display("FAIL a5_active_c1: got %b expected 1", act_log[p + 3]); end
    n_checks++; if (act_log[p + LAT - 1] !== 1'b1) begin n_fail++; $display("FAIL a5_active_stop: got %b expected 1", act_log[p + LAT - 1]); end
    n_checks++; if (act_log[p + LAT] !== 1'b0) begin n_fail++; $display("FAIL a5_active_after: got %b expected 0", act_log[p + LAT]); end
    $display("frame 0xA5: start at cycle %0d", p);
  endtask

  task automatic test_back_to_back();
    int b0, e0, p1, p2;
    b0 = dv_cyc.size();
    e0 = err_cyc.size();
    send_frame(8'h00, 1'b1);
    p1 = frame_p;
    send_frame(8'hFF, 1'b1);
    p2 = frame_p;
    idle(100);
    last_good = 8'hFF;
    n_checks++; if (dv_cyc.size() != b0 + 2) begin n_fail++; $display("FAIL b2b_dv_count: got %0d expected %0d", dv_cyc.size(), b0 + 2); end
    else begin
      n_checks++; if (dv_cyc[b0] != p1 + LAT)      begin n_fail++; $display("FAIL b2b_lat0: got %0d expected %0d", dv_cyc[b0] - p1, LAT); end
      n_checks++; if (dv_cyc[b0 + 1] != p2 + LAT)  begin n_fail++; $display("FAIL b2b_lat1: got %0d expected %0d", dv_cyc[b0 + 1] - p2, LAT); end
      n_checks++; if (dv_cyc[b0 + 1] - dv_cyc[b0] != 10 * N) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", dv_cyc[b0 + 1] - dv_cyc[b0], 10 * N); end
      n_checks++; if (dv_byte[b0] !== 8'h00)       begin n_fail++; $display("FAIL b2b_byte0: got %h expected 00", dv_byte[b0]); end
      n_checks++; if (dv_byte[b0 + 1] !== 8'hFF)   begin n_fail++; $display("FAIL b2b_byte1: got %h expected ff", dv_byte[b0 + 1]); end
    end
    n_checks++; if (err_cyc.size() != e0) begin n_fail++; $display("FAIL b2b_err: got %0d errors expected %0d", err_cyc.size(), e0); end
    $display("back-to-back 0x00,0xFF: starts %0d and %0d", p1, p2);
  endtask

  task automatic test_glitch();
    int b0, e0, p;
    b0 = dv_cyc.size();
    e0 = err_cyc.size();
    p = cyc;
    pin = 1'b0;
    idle(20);
    pin = 1'b1;
    idle(300);
    n_checks++; if (act_log[p + 2 + HALF] !== 1'b1)     begin n_fail++; $display("FAIL glitch_active_c43: got %b expected 1", act_log[p + 2 + HALF]); end
    n_checks++; if (act_log[p + 2 + HALF + 1] !== 1'b0) begin n_fail++; $display("FAIL glitch_active_c44: got %b expected 0", act_log[p + 2 + HALF + 1]); end
    n_checks++; if (dv_cyc.size() != b0)  begin n_fail++; $display("FAIL glitch_dv: got %0d pulses expected %0d", dv_cyc.size(), b0); end
    n_checks++; if (err_cyc.size() != e0) begin n_fail++; $display("FAIL glitch_err: got %0d errors expected %0d", err_cyc.size(), e0); end
    send_frame(8'h3C, 1'b1);
    p = frame_p;
    idle(100);
    last_good = 8'h3C;
    n_checks++; if (dv_cyc.size() != b0 + 1) begin n_fail++; $display("FAIL glitch_next_count: got %0d expected %0d", dv_cyc.size(), b0 + 1); end
    else begin
      n_checks++; if (dv_cyc[b0] != p + LAT)  begin n_fail++; $display("FAIL glitch_next_lat: got %0d expected %0d", dv_cyc[b0] - p, LAT); end
      n_checks++; if (dv_byte[b0] !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_byte: got %h expected 3c", dv_byte[b0]); end
    end
    $display("glitch 20 cycles, then frame 0x3C at cycle %0d", p);
  endtask

  task automatic test_frame_error();
    int b0, e0, p;
    b0 = dv_cyc.size();
    e0 = err_cyc.size();
    send_frame(8'h55, 1'b0);
    p = frame_p;
    idle(3000);
    pin = 1'b1;
    idle(200);
    n_checks++; if (err_cyc.size() != e0 + 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected %0d", err_cyc.size(), e0 + 1); end
    else begin
      n_checks++; if (err_cyc[e0] != p + LAT) begin n_fail++; $display("FAIL ferr_latency: got %0d expected %0d", err_cyc[e0] - p, LAT); end
    end
    n_checks++; if (dv_cyc.size() != b0)  begin n_fail++; $display("FAIL ferr_dv: got %0d pulses expected %0d", dv_cyc.size(), b0); end
    n_checks++; if (rx_byte !== last_good) begin n_fail++; $display("FAIL ferr_byte_kept: got %h expected %h", rx_byte, last_good); end
    send_frame(8'h81, 1'b1);
    p = frame_p;
    idle(100);
    last_good = 8'h81;
    n_checks++; if (dv_cyc.size() != b0 + 1) begin n_fail++; $display("FAIL ferr_next_count: got %0d expected %0d", dv_cyc.size(), b0 + 1); end
    else begin
      n_checks++; if (dv_cyc[b0] != p + LAT)  begin n_fail++; $display("FAIL ferr_next_lat: got %0d expected %0d", dv_cyc[b0] - p, LAT); end
      n_checks++; if (dv_byte[b0] !== 8'h81) begin n_fail++; $display("FAIL ferr_next_byte: got %h expected 81", dv_byte[b0]); end
    end
    n_checks++; if (err_cyc.size() != e0 + 1) begin n_fail++; $display("FAIL ferr_single: got %0d errors expected %0d", err_cyc.size(), e0 + 1); end
    $display("framing error 0x55 + 3000-cycle break, then frame 0x81 at cycle %0d", p);
  endtask

  task automatic test_reset_mid_frame();
    int b0, e0, p;
    b0 = dv_cyc.size();
    e0 = err_cyc.size();
    // Bits 6, 7 and stop of 0xE7 are high, so the line is idle after release.
    fork
      send_frame(8'hE7, 1'b1);
      begin
        idle(5 * N + 40);
        rst_n = 1'b0;
        #1;
        n_checks++; if (active !== 1'b0)   begin n_fail++; $display("FAIL rstmid_active: got %b expected 0", active); end
        n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL rstmid_byte: got %h expected 00", rx_byte); end
        n_checks++; if (dv !== 1'b0 || ferr !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses: got dv=%b err=%b expected 0 0", dv, ferr); end
        idle(2 * N);
        rst_n = 1'b1;
      end
    join
    last_good = 8'h00;
    idle(300);
    n_checks++; if (dv_cyc.size() != b0)  begin n_fail++; $display("FAIL rstmid_no_dv: got %0d pulses expected %0d", dv_cyc.size(), b0); end
    n_checks++; if (err_cyc.size() != e0) begin n_fail++; $display("FAIL rstmid_no_err: got %0d errors expected %0d", err_cyc.size(), e0); end
    send_frame(8'h42, 1'b1);
    p = frame_p;
    idle(100);
    last_good = 8'h42;
    n_checks++; if (dv_cyc.size() != b0 + 1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d expected %0d", dv_cyc.size(), b0 + 1); end
    else begin
      n_checks++; if (dv_cyc[b0] != p + LAT) begin n_fail++; $display("FAIL rstmid_next_lat: got %0d expected %0d", dv_cyc[b0] - p, LAT); end
    end
    n_checks++; if (rx_byte !== 8'h42) begin n_fail++; $display("FAIL rstmid_byte_42: got %h expected 42", rx_byte); end
    $display("reset during bit 4, then frame 0x42 at cycle %0d", p);
  endtask

  task automatic test_random_frames();
    int         b0, e0;
    int         exp_cyc[$];
    logic [7:0] exp_byte[$];
    logic [7:0] b;
    int         gap;
    b0 = dv_cyc.size();
    e0 = err_cyc.size();
    for (int i = 0; i < 6; i++) begin
      b   = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, 40));
      idle(gap);
      send_frame(b, 1'b1);
      exp_cyc.push_back(frame_p + LAT);
      exp_byte.push_back(b);
    end
    idle(100);
    last_good = exp_byte[exp_byte.size() - 1];
    n_checks++; if (dv_cyc.size() != b0 + 6) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", dv_cyc.size(), b0 + 6); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++; if (dv_cyc[b0 + i] != exp_cyc[i])    begin n_fail++; $display("FAIL rand_time[%0d]: got %0d expected %0d", i, dv_cyc[b0 + i], exp_cyc[i]); end
        n_checks++; if (dv_byte[b0 + i] !== exp_byte[i]) begin n_fail++; $display("FAIL rand_byte[%0d]: got %h expected %h", i, dv_byte[b0 + i], exp_byte[i]); end
        $display("random frame %0d: byte %h expected at cycle %0d", i, exp_byte[i], exp_cyc[i]);
      end
    end
    n_checks++; if (err_cyc.size() != e0)   begin n_fail++; $display("FAIL rand_err: got %0d errors expected %0d", err_cyc.size(), e0); end
    n_checks++; if (rx_byte !== last_good) begin n_fail++; $display("FAIL rand_byte_held: got %h expected %h", rx_byte, last_good); end
  endtask

  initial begin
    rst_n     = 1'b0;
    pin       = 1'b1;
    last_good = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_random_frames();
    n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL dv_err_overlap: got %0d cycles expected 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
